// File: rtl/din_router.sv
// Byte router: a two-entry in-order buffer of {sel, data} pairs feeding five ready/valid sinks.
// Invalid-destination bytes are dropped and counted, and a long-blocked head raises a sticky stall.
module din_router #(
    parameter int unsigned STALL_MAX = 16
) (
    input  logic       i_clkext,
    input  logic       i_rst_glo,
    input  logic [7:0] i_d_in,
    input  logic       i_din_vld,
    input  logic [2:0] i_sel_in,
    output logic       o_din_rdy,
    input  logic       i_flush,
    output logic [7:0] o_dst_data,
    output logic [4:0] o_dst_vld,
    input  logic [4:0] i_dst_rdy,
    output logic       o_err_sel,
    output logic [7:0] o_err_cnt,
    output logic       o_stall
);

    typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StFull = 2'd2} state_e;

    state_e     r_state, w_state_d;
    logic [7:0] r_data [2];
    logic [2:0] r_sel  [2];
    logic [7:0] w_data_d [2];
    logic [2:0] w_sel_d  [2];
    logic [7:0] r_stall_cnt, w_stall_cnt_d;
    logic       r_stall, w_stall_d;
    logic       r_err_sel;
    logic [7:0] r_err_cnt, w_err_cnt_d;

    logic w_not_empty;
    logic w_head_ok;
    logic w_head_bad;
    logic w_xfer;
    logic w_pop;
    logic w_push;
    logic w_wr_idx;

    assign w_not_empty = (r_state != StEmpty);
    assign w_head_ok   = w_not_empty && (r_sel[0] <= 3'd4);
    assign w_head_bad  = w_not_empty && (r_sel[0] > 3'd4);

    assign o_din_rdy  = (r_state != StFull) && !i_flush;
    assign o_dst_data = w_not_empty ? r_data[0] : 8'h00;
    assign o_err_sel  = r_err_sel;
    assign o_err_cnt  = r_err_cnt;
    assign o_stall    = r_stall;

    always_comb begin
        o_dst_vld = 5'b00000;
        if (w_head_ok) begin
            unique case (r_sel[0])
                3'd0:    o_dst_vld = 5'b00001;
                3'd1:    o_dst_vld = 5'b00010;
                3'd2:    o_dst_vld = 5'b00100;
                3'd3:    o_dst_vld = 5'b01000;
                default: o_dst_vld = 5'b10000;
            endcase
        end
    end

    // Invalid heads leave unconditionally; flush voids every pop and push in its cycle.
    assign w_xfer   = |(o_dst_vld & i_dst_rdy);
    assign w_pop    = (w_xfer || w_head_bad) && !i_flush;
    assign w_push   = i_din_vld && o_din_rdy;
    assign w_wr_idx = (r_state == StOne) && !w_pop;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StEmpty: if (w_push) w_state_d = StOne;
            StOne: begin
                if (w_push && !w_pop)      w_state_d = StFull;
                else if (w_pop && !w_push) w_state_d = StEmpty;
            end
            StFull:  if (w_pop) w_state_d = StOne;
            default: w_state_d = StEmpty;
        endcase
        if (i_flush) w_state_d = StEmpty;
    end

    always_comb begin
        w_data_d = r_data;
        w_sel_d  = r_sel;
        if (w_pop) begin
            w_data_d[0] = r_data[1];
            w_sel_d[0]  = r_sel[1];
        end
        if (w_push) begin
            w_data_d[w_wr_idx] = i_d_in;
            w_sel_d[w_wr_idx]  = i_sel_in;
        end
    end

    always_comb begin
        w_stall_cnt_d = 8'd0;
        w_stall_d     = r_stall;
        w_err_cnt_d   = r_err_cnt;
        if (i_flush) begin
            w_stall_d = 1'b0;
        end else begin
            if (w_head_ok && !w_xfer) begin
                w_stall_cnt_d = (r_stall_cnt == 8'hFF) ? r_stall_cnt : r_stall_cnt + 8'd1;
                if (32'(w_stall_cnt_d) >= STALL_MAX) w_stall_d = 1'b1;
            end
            if (w_head_bad && r_err_cnt != 8'hFF) w_err_cnt_d = r_err_cnt + 8'd1;
        end
    end

    always_ff @(posedge i_clkext or posedge i_rst_glo) begin
        if (i_rst_glo) begin
            r_state     <= StEmpty;
            r_data[0]   <= 8'h00;
            r_data[1]   <= 8'h00;
            r_sel[0]    <= 3'd0;
            r_sel[1]    <= 3'd0;
            r_stall_cnt <= 8'd0;
            r_stall     <= 1'b0;
            r_err_sel   <= 1'b0;
            r_err_cnt   <= 8'd0;
        end else begin
            r_state     <= w_state_d;
            r_data      <= w_data_d;
            r_sel       <= w_sel_d;
            r_stall_cnt <= w_stall_cnt_d;
            r_stall     <= w_stall_d;
            r_err_sel   <= w_head_bad && !i_flush;
            r_err_cnt   <= w_err_cnt_d;
        end
    end

endmodule

// File: tb/tb_din_router.sv
// Directed table-driven bench for din_router (STALL_MAX=4), plus hand sequences for
// error-count saturation and asynchronous reset mid-operation.
module tb_din_router;

    logic       clk;
    logic       rst;
    logic [7:0] d_in;
    logic       din_vld;
    logic [2:0] sel_in;
    logic       din_rdy;
    logic       flush;
    logic [7:0] dst_data;
    logic [4:0] dst_vld;
    logic [4:0] dst_rdy;
    logic       err_sel;
    logic [7:0] err_cnt;
    logic       stall;

    int n_checks = 0;
    int n_err    = 0;

    din_router #(.STALL_MAX(4)) dut (
        .i_clkext  (clk),
        .i_rst_glo (rst),
        .i_d_in    (d_in),
        .i_din_vld (din_vld),
        .i_sel_in  (sel_in),
        .o_din_rdy (din_rdy),
        .i_flush   (flush),
        .o_dst_data(dst_data),
        .o_dst_vld (dst_vld),
        .i_dst_rdy (dst_rdy),
        .o_err_sel (err_sel),
        .o_err_cnt (err_cnt),
        .o_stall   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       flush;
        logic       vld;
        logic [2:0] sel;
        logic [7:0] din;
        logic [4:0] rdy;
        logic       e_rdy;
        logic [4:0] e_vld;
        logic [7:0] e_data;
        logic       e_err;
        logic [7:0] e_cnt;
        logic       e_stall;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_rdy, input logic [4:0] e_vld,
                           input logic [7:0] e_data, input logic e_err, input logic [7:0] e_cnt,
                           input logic e_stall);
        chk({tag, " din_rdy"}, {7'd0, din_rdy}, {7'd0, e_rdy});
        chk({tag, " dst_vld"}, {3'd0, dst_vld}, {3'd0, e_vld});
        chk({tag, " dst_data"}, dst_data, e_data);
        chk({tag, " err_sel"}, {7'd0, err_sel}, {7'd0, e_err});
        chk({tag, " err_cnt"}, err_cnt, e_cnt);
        chk({tag, " stall"}, {7'd0, stall}, {7'd0, e_stall});
    endtask

    task automatic drive(input logic f, input logic v, input logic [2:0] s, input logic [7:0] d,
                         input logic [4:0] r);
        flush   = f;
        din_vld = v;
        sel_in  = s;
        d_in    = d;
        dst_rdy = r;
    endtask

    initial begin
        // flush vld sel din rdy | rdy vld data err cnt stall
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b00000, 1, 5'b00000, 8'h00, 0, 8'd0, 0});
        vecs.push_back('{0, 1, 3'd2, 8'hA5, 5'b11111, 1, 5'b00000, 8'h00, 0, 8'd0, 0});
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b11111, 1, 5'b00100, 8'hA5, 0, 8'd0, 0});
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b00000, 1, 5'b00000, 8'h00, 0, 8'd0, 0});
        // Backpressure towards mac
        vecs.push_back('{0, 1, 3'd4, 8'h11, 5'b00000, 1, 5'b00000, 8'h00, 0, 8'd0, 0});
        vecs.push_back('{0, 1, 3'd4, 8'h22, 5'b00000, 1, 5'b10000, 8'h11, 0, 8'd0, 0});
        vecs.push_back('{0, 1, 3'd4, 8'h33, 5'b00000, 0, 5'b10000, 8'h11, 0, 8'd0, 0});
        vecs.push_back('{0, 1, 3'd4, 8'h33, 5'b10000, 0, 5'b10000, 8'h11, 0, 8'd0, 0});
        vecs.push_back('{0, 1, 3'd4, 8'h33, 5'b10000, 1, 5'b10000, 8'h22, 0, 8'd0, 0});
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b10000, 1, 5'b10000, 8'h33, 0, 8'd0, 0});
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b00000, 1, 5'b00000, 8'h00, 0, 8'd0, 0});
        // Only the head's own ready bit matters
        vecs.push_back('{0, 1, 3'd1, 8'h44, 5'b00000, 1, 5'b00000, 8'h00, 0, 8'd0, 0});
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b11101, 1, 5'b00010, 8'h44, 0, 8'd0, 0});
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b00010, 1, 5'b00010, 8'h44, 0, 8'd0, 0});
        // Invalid destination
        vecs.push_back('{0, 1, 3'd6, 8'h3C, 5'b11111, 1, 5'b00000, 8'h00, 0, 8'd0, 0});
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b11111, 1, 5'b00000, 8'h3C, 0, 8'd0, 0});
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b11111, 1, 5'b00000, 8'h00, 1, 8'd1, 0});
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b11111, 1, 5'b00000, 8'h00, 0, 8'd1, 0});
        // Stall on relu
        vecs.push_back('{0, 1, 3'd3, 8'h77, 5'b00000, 1, 5'b00000, 8'h00, 0, 8'd1, 0});
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b10111, 1, 5'b01000, 8'h77, 0, 8'd1, 0});
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b00000, 1, 5'b01000, 8'h77, 0, 8'd1, 0});
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b00000, 1, 5'b01000, 8'h77, 0, 8'd1, 0});
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b00000, 1, 5'b01000, 8'h77, 0, 8'd1, 0});
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b00000, 1, 5'b01000, 8'h77, 0, 8'd1, 1});
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b01000, 1, 5'b01000, 8'h77, 0, 8'd1, 1});
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b00000, 1, 5'b00000, 8'h00, 0, 8'd1, 1});
        vecs.push_back('{1, 0, 3'd0, 8'h00, 5'b00000, 0, 5'b00000, 8'h00, 0, 8'd1, 1});
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b00000, 1, 5'b00000, 8'h00, 0, 8'd1, 0});
        // Flush a full buffer; the concurrent transfer and push are void
        vecs.push_back('{0, 1, 3'd0, 8'h55, 5'b00000, 1, 5'b00000, 8'h00, 0, 8'd1, 0});
        vecs.push_back('{0, 1, 3'd0, 8'h66, 5'b00000, 1, 5'b00001, 8'h55, 0, 8'd1, 0});
        vecs.push_back('{1, 1, 3'd0, 8'h99, 5'b00001, 0, 5'b00001, 8'h55, 0, 8'd1, 0});
        vecs.push_back('{0, 0, 3'd0, 8'h00, 5'b00001, 1, 5'b00000, 8'h00, 0, 8'd1, 0});

        rst = 1'b1;
        drive(0, 0, 3'd0, 8'h00, 5'b00000);
        #12;
        chk_all("reset", 1, 5'b00000, 8'h00, 0, 8'd0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].flush, vecs[i].vld, vecs[i].sel, vecs[i].din, vecs[i].rdy);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_vld, vecs[i].e_data,
                    vecs[i].e_err, vecs[i].e_cnt, vecs[i].e_stall);
            @(negedge clk);
        end

        // Stream invalid bytes back-to-back; count must stick at 255.
        for (int i = 0; i < 300; i++) begin
            drive(0, 1, 3'd7, 8'(i), 5'b11111);
            @(negedge clk);
        end
        #1;
        chk("stream err_sel", {7'd0, err_sel}, 8'd1);
        drive(0, 0, 3'd0, 8'h00, 5'b00000);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("sat err_cnt", err_cnt, 8'd255);
        chk("sat err_sel", {7'd0, err_sel}, 8'd0);
        chk("sat dst_vld", {3'd0, dst_vld}, 8'd0);

        // Fill the buffer, then hit reset asynchronously in the middle of the high phase.
        drive(0, 1, 3'd4, 8'hC1, 5'b00000);
        @(negedge clk);
        drive(0, 1, 3'd4, 8'hC2, 5'b00000);
        @(negedge clk);
        drive(0, 0, 3'd0, 8'h00, 5'b00000);
        #1;
        chk("full din_rdy", {7'd0, din_rdy}, 8'd0);
        chk("full dst_data", dst_data, 8'hC1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all("async rst", 1, 5'b00000, 8'h00, 0, 8'd0, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 3'd0, 8'h00, 5'b11111);
        @(posedge clk);
        #1;
        chk_all("post rst", 1, 5'b00000, 8'h00, 0, 8'd0, 0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
